// File: rtl/a_priority_thresh_selector.sv
// Bus-grant decision unit: combinational fixed-priority / pre-emption selector plus a
// registered bus-hold threshold counter. Optional macro: A_THRESH_PREEMPT_EN (round-robin pre-emption once thresh is high).
module a_priority_thresh_selector #(
  parameter int NO_MASTERS = 2,
  parameter int NO_SLAVES  = 3,
  parameter int THRESH     = 1000,
  parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
  parameter int M_ID_WIDTH = (NO_MASTERS > 1) ? $clog2(NO_MASTERS) : 1,
  parameter int CNT_WIDTH  = $clog2(THRESH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  state,
  input  logic [M_ID_WIDTH-1:0] master_in,
  input  logic [S_ID_WIDTH-1:0] slave_in,
  input  logic [S_ID_WIDTH-1:0] slave_id [NO_MASTERS],
  output logic [M_ID_WIDTH-1:0] master_out,
  output logic [S_ID_WIDTH-1:0] slave_out,
  output logic                  request,
  output logic                  thresh
);

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [M_ID_WIDTH-1:0] last_master_q, last_master_d;
  logic [NO_MASTERS-1:0] valid;
  logic                  found;
  logic [M_ID_WIDTH-1:0] sel_m;
  logic [S_ID_WIDTH-1:0] sel_s;

  always_comb begin
    valid = '0;
    for (int m = 0; m < NO_MASTERS; m++)
      valid[m] = (slave_id[m] != '0) && (int'(slave_id[m]) <= NO_SLAVES);
  end

  // Loops run from the far end so the last hit (the preferred master) overwrites earlier ones.
  always_comb begin
    found = 1'b0;
    sel_m = '0;
    sel_s = '0;
    if (!state) begin
      for (int m = NO_MASTERS - 1; m >= 0; m--)
        if (valid[m]) begin
          found = 1'b1;
          sel_m = M_ID_WIDTH'(m);
          sel_s = slave_id[m];
        end
    end
`ifdef A_THRESH_PREEMPT_EN
    else if (thresh) begin
      for (int k = NO_MASTERS - 1; k >= 1; k--)
        for (int m = 0; m < NO_MASTERS; m++)
          if (valid[m] && (((int'(master_in) + k) % NO_MASTERS) == m)) begin
            found = 1'b1;
            sel_m = M_ID_WIDTH'(m);
            sel_s = slave_id[m];
          end
    end
`endif
    else begin
      for (int m = NO_MASTERS - 1; m >= 0; m--)
        if (valid[m] && (m < int'(master_in))) begin
          found = 1'b1;
          sel_m = M_ID_WIDTH'(m);
          sel_s = slave_id[m];
        end
    end
    request    = found;
    master_out = found ? sel_m : (state ? master_in : '0);
    slave_out  = found ? sel_s : (state ? slave_in : '0);
  end

  // Hold counter restarts at 1 on an owner change and saturates at THRESH.
  always_comb begin
    cnt_d         = cnt_q;
    last_master_d = master_in;
    if (!state)
      cnt_d = '0;
    else if (master_in != last_master_q)
      cnt_d = CNT_WIDTH'(1);
    else if (cnt_q != CNT_WIDTH'(THRESH))
      cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      last_master_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      last_master_q <= last_master_d;
    end
  end

  assign thresh = (cnt_q == CNT_WIDTH'(THRESH));

endmodule

// File: tb/tb_a_priority_thresh_selector.sv
// Randomized self-checking bench for a_priority_thresh_selector: two instances
// (2 masters / THRESH 4 and 4 masters / THRESH 6) compared against a behavioural model.
module tb_a_priority_thresh_selector;

  localparam int NM_A = 2, NS_A = 3, T_A = 4, SW_A = 2, MW_A = 1;
  localparam int NM_B = 4, NS_B = 5, T_B = 6, SW_B = 3, MW_B = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            st_a, req_a, th_a;
  logic [MW_A-1:0] mi_a, mo_a;
  logic [SW_A-1:0] si_a, so_a;
  logic [SW_A-1:0] id_a [NM_A];

  logic            st_b, req_b, th_b;
  logic [MW_B-1:0] mi_b, mo_b;
  logic [SW_B-1:0] si_b, so_b;
  logic [SW_B-1:0] id_b [NM_B];

  int n_tests = 0, n_fail = 0;
  int hold_a = 0, prev_a = 0, hold_b = 0, prev_b = 0;

  a_priority_thresh_selector #(.NO_MASTERS(NM_A), .NO_SLAVES(NS_A), .THRESH(T_A)) u_dut_a (
    .clk(clk), .rst(rst), .state(st_a), .master_in(mi_a), .slave_in(si_a), .slave_id(id_a),
    .master_out(mo_a), .slave_out(so_a), .request(req_a), .thresh(th_a));

  a_priority_thresh_selector #(.NO_MASTERS(NM_B), .NO_SLAVES(NS_B), .THRESH(T_B)) u_dut_b (
    .clk(clk), .rst(rst), .state(st_b), .master_in(mi_b), .slave_in(si_b), .slave_id(id_b),
    .master_out(mo_b), .slave_out(so_b), .request(req_b), .thresh(th_b));

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Consecutive cycles the current owner has held the bus in STOP, capped at t.
  task automatic hold_upd(input int t, input bit r, input bit s, input int mi,
                          inout int hold, inout int prev);
    if (r) begin
      hold = 0;
      prev = 0;
    end else begin
      if (!s)             hold = 0;
      else if (mi != prev) hold = 1;
      else if (hold < t)   hold = hold + 1;
      prev = mi;
    end
  endtask

  task automatic ref_sel(input int nm, input int ns, input bit s, input int mi, input int si,
                         input int ids[8], input bit th, output int req, output int mo, output int so);
    bit pre;
    int c;
    req = 0;
    mo  = s ? mi : 0;
    so  = s ? si : 0;
`ifdef A_THRESH_PREEMPT_EN
    pre = s && th;
`else
    pre = 1'b0;
`endif
    if (!s) begin
      for (int m = 0; m < nm; m++)
        if (req == 0 && ids[m] >= 1 && ids[m] <= ns) begin req = 1; mo = m; so = ids[m]; end
    end else if (pre) begin
      for (int k = 1; k < nm; k++) begin
        c = (mi + k) % nm;
        if (req == 0 && ids[c] >= 1 && ids[c] <= ns) begin req = 1; mo = c; so = ids[c]; end
      end
    end else begin
      for (int m = 0; m < mi; m++)
        if (req == 0 && ids[m] >= 1 && ids[m] <= ns) begin req = 1; mo = m; so = ids[m]; end
    end
  endtask

  task automatic check_a();
    int ids[8];
    int rq, mo, so;
    ids = '{default: 0};
    for (int m = 0; m < NM_A; m++) ids[m] = int'(id_a[m]);
    ref_sel(NM_A, NS_A, st_a, int'(mi_a), int'(si_a), ids, hold_a == T_A, rq, mo, so);
    chk("a_thresh", int'(th_a), int'(hold_a == T_A));
    chk("a_request", int'(req_a), rq);
    chk("a_master_out", int'(mo_a), mo);
    chk("a_slave_out", int'(so_a), so);
  endtask

  task automatic check_b();
    int ids[8];
    int rq, mo, so;
    ids = '{default: 0};
    for (int m = 0; m < NM_B; m++) ids[m] = int'(id_b[m]);
    ref_sel(NM_B, NS_B, st_b, int'(mi_b), int'(si_b), ids, hold_b == T_B, rq, mo, so);
    chk("b_thresh", int'(th_b), int'(hold_b == T_B));
    chk("b_request", int'(req_b), rq);
    chk("b_master_out", int'(mo_b), mo);
    chk("b_slave_out", int'(so_b), so);
  endtask

  task automatic tick();
    @(posedge clk);
    hold_upd(T_A, rst, st_a, int'(mi_a), hold_a, prev_a);
    hold_upd(T_B, rst, st_b, int'(mi_b), hold_b, prev_b);
    #1;
  endtask

  task automatic set_a(input bit s, input int mi, input int si, input int i0, input int i1);
    st_a = s;
    mi_a = MW_A'(mi);
    si_a = SW_A'(si);
    id_a[0] = SW_A'(i0);
    id_a[1] = SW_A'(i1);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    st_a = 1'b0; mi_a = '0; si_a = '0;
    st_b = 1'b0; mi_b = '0; si_b = '0;
    for (int m = 0; m < NM_A; m++) id_a[m] = '0;
    for (int m = 0; m < NM_B; m++) id_b[m] = '0;
    tick();
    tick();
    chk("rst_thresh_a", int'(th_a), 0);
    chk("rst_thresh_b", int'(th_b), 0);
    check_a();
    rst = 1'b0;

    // Fixed-priority grants in NRML
    set_a(1'b0, 0, 0, 2, 3); check_a();
    chk("nrml_m0_master", int'(mo_a), 0); chk("nrml_m0_slave", int'(so_a), 2);
    set_a(1'b0, 0, 0, 0, 3); check_a();
    chk("nrml_m1_master", int'(mo_a), 1); chk("nrml_m1_slave", int'(so_a), 3);
    set_a(1'b0, 0, 0, 0, 0); check_a();
    chk("nrml_none_req", int'(req_a), 0);

    // STOP without thresh: only a lower index can pre-empt
    set_a(1'b1, 1, 3, 1, 3); check_a();
    chk("stop_pre_req", int'(req_a), 1); chk("stop_pre_master", int'(mo_a), 0);
    set_a(1'b1, 0, 3, 1, 3); check_a();
    chk("stop_none_req", int'(req_a), 0); chk("stop_none_slave", int'(so_a), 3);

    // Hold counting from reset with a stable owner
    rst = 1'b1; set_a(1'b0, 0, 0, 0, 0); tick(); rst = 1'b0;
    set_a(1'b1, 0, 1, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      tick(); check_a();
      chk("hold_thresh", int'(th_a), int'(i >= T_A));
    end
    set_a(1'b1, 0, 1, 0, 2); check_a();
`ifdef A_THRESH_PREEMPT_EN
    chk("rr_req", int'(req_a), 1); chk("rr_master", int'(mo_a), 1); chk("rr_slave", int'(so_a), 2);
`else
    chk("rr_req", int'(req_a), 0); chk("rr_master", int'(mo_a), 0); chk("rr_slave", int'(so_a), 1);
`endif

    // Owner change restarts the count
    set_a(1'b1, 1, 1, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick(); check_a();
      chk("owner_chg_thresh", int'(th_a), int'(i >= T_A));
    end
    set_a(1'b0, 1, 1, 0, 0); tick(); check_a();
    chk("nrml_clear", int'(th_a), 0);

    // Reset mid-hold, then restart while STOP is held
    set_a(1'b1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin tick(); check_a(); end
    rst = 1'b1; tick(); check_a(); chk("rst_mid_hold", int'(th_a), 0);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(); check_a();
      chk("restart_thresh", int'(th_a), int'(i >= T_A));
    end

    // Random traffic on both instances, biased toward long stable holds
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      st_a = ($urandom_range(0, 99) >= 6);
      st_b = ($urandom_range(0, 99) >= 5);
      if ($urandom_range(0, 99) < 6) mi_a = MW_A'($urandom_range(0, NM_A - 1));
      if ($urandom_range(0, 99) < 4) mi_b = MW_B'($urandom_range(0, NM_B - 1));
      si_a = SW_A'($urandom_range(0, 3));
      si_b = SW_B'($urandom_range(0, 7));
      for (int m = 0; m < NM_A; m++) id_a[m] = SW_A'($urandom_range(0, 3));
      for (int m = 0; m < NM_B; m++) id_b[m] = SW_B'($urandom_range(0, 7));
      #1;
      check_a();
      check_b();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
